ks10_bus_arbiter: RTL and testbench
===================================

// Module: ks10_bus_arbiter
// PURPOSE
//   Shares the single KS10 backplane bus between NREQ masters (CPU, console
//   interface, UBA DMA engines). Grants one master at a time and drives the
//   shared addr/data/req lines from the winner. Holds the grant until the
//   slave acknowledges or a timeout expires, then returns data/ack to the winner.
//   Sits between the master REQO/ADDRO/DATAO outputs and the backplane slaves.
// PARAMETERS
//   NREQ     4    number of masters; index 0 is highest fixed priority (CPU)
//   TIMEOUT  63   cycles in WAIT before NXM abort; legal range 1..255
// PORTS
//   clk       in   1        bus clock; all state on rising edge
//   rst       in   1        synchronous, active-high reset
//   reqIN     in   NREQ     per-master request; held high until ackOUT/nxmOUT
//   addrIN    in   NREQ*36  per-master addr+flags; master i at [i*36 +: 36]
//   dataIN    in   NREQ*36  per-master write data; same packing
//   ackOUT    out  NREQ     one-cycle pulse to granted master on completion
//   nxmOUT    out  NREQ     one-cycle pulse to granted master on timeout
//   dataOUT   out  36       read data captured on busACKI; shared by all masters
//   busREQO   out  1        backplane request, high for whole bus cycle
//   busADDRO  out  36       addr of granted master; registered at grant
//   busDATAO  out  36       write data of granted master; registered at grant
//   busACKI   in   1        slave acknowledge; data valid on busDATAI same cycle
//   busDATAI  in   36       slave read data
//   grantOUT  out  NREQ     one-hot current grant; all-zero when idle
// BEHAVIOUR
//   - States: IDLE -> WAIT -> DONE -> IDLE. DONE is a one-cycle bus turnaround.
//   - IDLE: if any reqIN, latch winner into grant; load busADDRO/busDATAO;
//     set busREQO. Request at edge n gives busREQO high after edge n+1.
//   - WAIT: busREQO high; addr/data frozen, even if master changes inputs.
//     busACKI -> capture busDATAI into dataOUT, pulse ackOUT[g], go to DONE.
//     Count reaches TIMEOUT with no ack -> pulse nxmOUT[g], go to DONE.
//   - DONE: busREQO=0, grant cleared, no arbitration; next grant earliest
//     on the following cycle. Minimum 3 cycles per transaction.
//   - Timeout counter: 8 bits, cleared on entry to WAIT, saturates.
//     busACKI on the same cycle as the timeout wins: ack, no nxm.
//   - busACKI in IDLE or DONE is ignored; dataOUT is unchanged.
//   - Master drops reqIN during WAIT: the bus cycle still completes and
//     ackOUT/nxmOUT still pulse. Masters must hold reqIN until then.
//   - A master whose ackOUT pulsed may re-request at once; it is eligible
//     at the first IDLE cycle after DONE.
//   - Reset: at the next edge all outputs go to 0 (busREQO, busADDRO,
//     busDATAO, dataOUT, ackOUT, nxmOUT, grantOUT), state=IDLE, counter=0,
//     and the round-robin pointer (if built) =0. A transaction in flight
//     at reset is abandoned with no ack/nxm.
//   - ackOUT, nxmOUT and grantOUT are one-hot or zero; they never assert
//     for a non-granted master.
// CONFIGURATION
//   KS10_ARB_ROUNDROBIN_EN
//     undefined: fixed priority; the lowest requesting index wins.
//     defined:   rotating priority. A pointer holds last-granted+1 mod NREQ.
//                Search starts at the pointer and wraps past NREQ-1 to 0.
//                The pointer updates on the IDLE->WAIT transition only.
// TESTING
//   1 Single read: reqIN=0001, addrIN[0]=36'o000000001000, busACKI 4 cycles
//     after busREQO, busDATAI=36'o123456654321 -> ackOUT=0001 one cycle,
//     dataOUT=36'o123456654321, busREQO high exactly 4 cycles.
//   2 Contention, fixed priority: reqIN=1111 held -> grants in order
//     0,0,0...; master 3 is never granted while master 0 keeps requesting.
//     With KS10_ARB_ROUNDROBIN_EN: grant order 0,1,2,3,0.
//   3 Timeout: reqIN=0100, busACKI never -> nxmOUT=0100 pulse exactly
//     TIMEOUT cycles after WAIT entry, ackOUT stays 0, bus idle in DONE.
//   4 Ack on the timeout cycle: busACKI on cycle TIMEOUT -> ackOUT pulses,
//     nxmOUT stays 0.
//   5 Reset mid-WAIT: rst asserted 2 cycles into WAIT -> all outputs 0 next
//     cycle; no ack/nxm. After release, a pending req is re-granted normally.
//   6 Input stability: master changes addrIN during WAIT -> busADDRO unchanged
//     until DONE.

Source files
------------

// File: rtl/ks10_bus_arbiter.sv
// ks10_bus_arbiter: grants the shared KS10 backplane to one of NREQ masters per bus cycle.
// Fixed priority by default; define KS10_ARB_ROUNDROBIN_EN for rotating priority.
module ks10_bus_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 63
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    reqIN,
   input  logic [NREQ*36-1:0] addrIN,
   input  logic [NREQ*36-1:0] dataIN,
   output logic [NREQ-1:0]    ackOUT,
   output logic [NREQ-1:0]    nxmOUT,
   output logic [35:0]        dataOUT,
   output logic               busREQO,
   output logic [35:0]        busADDRO,
   output logic [35:0]        busDATAO,
   input  logic               busACKI,
   input  logic [35:0]        busDATAI,
   output logic [NREQ-1:0]    grantOUT
);
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t state, state_nx;
   logic [7:0] cnt;
   logic [IW-1:0] win;
   logic grant, finish;
`ifdef KS10_ARB_ROUNDROBIN_EN
   logic [IW-1:0] ptr;
   always_ff @(posedge clk)
      if (rst) ptr <= '0;
      else if (grant) ptr <= IW'((int'(win) + 1) % NREQ);
`else
   localparam logic [IW-1:0] ptr = '0;
`endif
   // Descending scan so the requester closest to ptr is the last (winning) assignment.
   always_comb begin
      win = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (reqIN[(int'(ptr) + k) % NREQ]) win = IW'((int'(ptr) + k) % NREQ);
   end
   assign grant  = state == IDLE && |reqIN;
   assign finish = state == WAIT && (busACKI || cnt == TLAST);
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (grant ? WAIT : IDLE) :
                 state == WAIT ? (finish ? DONE : WAIT) : IDLE;
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         grantOUT <= '0;
         ackOUT   <= '0;
         nxmOUT   <= '0;
         dataOUT  <= '0;
         busREQO  <= 1'b0;
         busADDRO <= '0;
         busDATAO <= '0;
      end else begin
         ackOUT <= '0;
         nxmOUT <= '0;
         if (grant) begin
            grantOUT <= NREQ'(1) << win;
            busADDRO <= addrIN[int'(win)*36 +: 36];
            busDATAO <= dataIN[int'(win)*36 +: 36];
            busREQO  <= 1'b1;
            cnt      <= '0;
         end else if (state == WAIT) begin
            cnt <= cnt == 8'hFF ? cnt : cnt + 8'd1;
            // An ack arriving on the timeout cycle takes precedence over the abort.
            if (busACKI) begin
               dataOUT <= busDATAI;
               ackOUT  <= grantOUT;
            end else if (finish) nxmOUT <= grantOUT;
            if (finish) begin
               grantOUT <= '0;
               busREQO  <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ks10_bus_arbiter.sv
// tb_ks10_bus_arbiter: randomized scoreboard bench for ks10_bus_arbiter.
// Honours KS10_ARB_ROUNDROBIN_EN the same way the design does.
module tb_ks10_bus_arbiter;
   localparam int N = 4, TO = 63;
   logic clk = 0, rst = 1;
   logic [N-1:0] reqIN = '0;
   logic [N*36-1:0] addrIN = '0, dataIN = '0;
   logic [N-1:0] ackOUT, nxmOUT, grantOUT;
   logic [35:0] dataOUT, busADDRO, busDATAO, busDATAI = '0;
   logic busREQO, busACKI = 0;
   int total = 0, bad = 0;
   typedef struct {int m; bit ack; logic [35:0] addr, wdata, rdata; int len;} exp_t;
   exp_t q[$];
   exp_t e;
   bit mon_en = 0;
   int run = 0, ptr = 0, last_w = 0;
   logic [35:0] model_rd = '0;

   ks10_bus_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .reqIN(reqIN), .addrIN(addrIN), .dataIN(dataIN),
      .ackOUT(ackOUT), .nxmOUT(nxmOUT), .dataOUT(dataOUT), .busREQO(busREQO),
      .busADDRO(busADDRO), .busDATAO(busDATAO), .busACKI(busACKI),
      .busDATAI(busDATAI), .grantOUT(grantOUT));

   always #5 clk = ~clk;
   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int m);
      return N'(1) << m;
   endfunction

   function automatic logic [35:0] r36();
      return 36'({$urandom(), $urandom()}) | 36'd1;
   endfunction

   // Priority from the rules: first requester at or after the pointer, wrapping.
   task automatic pick(output int w);
      w = -1;
      for (int k = 0; k < N; k++)
         if (w < 0 && reqIN[(ptr + k) % N]) w = (ptr + k) % N;
`ifdef KS10_ARB_ROUNDROBIN_EN
      ptr = (w + 1) % N;
`endif
   endtask

   task automatic request(input int i);
      reqIN[i] = 1'b1;
      addrIN[i*36 +: 36] = r36();
      dataIN[i*36 +: 36] = r36();
   endtask

   // Called at a negedge with reqIN already presented; returns at the DONE negedge.
   task automatic run_txn(input int d, input logic [35:0] rd, input bit poke);
      int w, k;
      exp_t x;
      pick(w);
      last_w = w;
      x.m = w;
      x.ack = d <= TO;
      x.addr = addrIN[w*36 +: 36];
      x.wdata = dataIN[w*36 +: 36];
      x.len = x.ack ? d : TO;
      if (x.ack) model_rd = rd;
      x.rdata = model_rd;
      q.push_back(x);
      k = 0;
      while (!busREQO) begin
         @(negedge clk);
         k++;
         if (k > 8) begin
            chk("grant_wait", {63'd0, busREQO}, 64'd1);
            return;
         end
      end
      k = 1;
      while (busREQO && k <= TO + 8) begin
         busACKI = k == d;
         busDATAI = k == d ? rd : r36();
         if (poke && k == 2) addrIN[w*36 +: 36] = ~addrIN[w*36 +: 36];
         @(negedge clk);
         k++;
      end
      busACKI = 0;
   endtask

   // Winner drops its request; others (and optionally the winner again) may request.
   task automatic next_reqs(input int pct);
      reqIN[last_w] = 1'b0;
      for (int i = 0; i < N; i++)
         if (!reqIN[i] && $urandom_range(99) < pct) request(i);
      if (reqIN == '0) request($urandom_range(N - 1));
      busACKI = $urandom_range(1) == 1;
      busDATAI = r36();
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (busREQO) begin
            run++;
            if (q.size() == 0) chk("unexpected_grant", {busREQO, grantOUT}, 0);
            else begin
               chk("grant", grantOUT, oh(q[0].m));
               chk("bus_addr", busADDRO, q[0].addr);
               if (run == 1) chk("bus_wdata", busDATAO, q[0].wdata);
            end
         end
         if (|ackOUT || |nxmOUT) begin
            if (q.size() == 0) chk("unexpected_done", {ackOUT, nxmOUT}, 0);
            else begin
               e = q.pop_front();
               chk("ack", ackOUT, e.ack ? oh(e.m) : '0);
               chk("nxm", nxmOUT, e.ack ? '0 : oh(e.m));
               chk("data_out", dataOUT, e.rdata);
               chk("req_len", run, e.len);
               chk("done_idle", {busREQO, grantOUT}, 0);
            end
            run = 0;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ctl", {busREQO, grantOUT, ackOUT, nxmOUT}, 0);
      chk("rst_data", {busADDRO, busDATAO} | 72'(dataOUT), 0);
      rst = 0;
      mon_en = 1;
      // Single read with an input change mid-cycle.
      reqIN = 4'b0001;
      addrIN[35:0] = 36'o000000001000;
      dataIN[35:0] = r36();
      run_txn(4, 36'o123456654321, 1);
      // Timeout, then ack exactly on the timeout cycle.
      reqIN = '0;
      request(2);
      run_txn(TO + 5, r36(), 0);
      request(2);
      run_txn(TO, r36(), 1);
      // Full contention with everyone re-requesting at once.
      reqIN = '0;
      for (int i = 0; i < N; i++) request(i);
      for (int t = 0; t < 6; t++) begin
         run_txn($urandom_range(1, 6), r36(), 0);
         request(last_w);
      end
      // Abandoned transaction: reset two cycles into WAIT.
      @(negedge clk);
      wait (!busREQO && !(|ackOUT));
      mon_en = 0;
      q.delete();
      reqIN = '0;
      request(2);
      for (int k = 0; k < 8 && !busREQO; k++) @(negedge clk);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("midrst_ctl", {busREQO, grantOUT, ackOUT, nxmOUT}, 0);
      chk("midrst_data", {busADDRO, busDATAO} | 72'(dataOUT), 0);
      @(negedge clk);
      chk("midrst_noack", {ackOUT, nxmOUT}, 0);
      ptr = 0;
      model_rd = '0;
      run = 0;
      rst = 0;
      mon_en = 1;
      run_txn(3, r36(), 0);
      // Random traffic.
      for (int t = 0; t < 100; t++) begin
         next_reqs(40);
         run_txn($urandom_range(3) == 0 ? $urandom_range(TO, TO + 4) : $urandom_range(1, 10),
                 r36(), $urandom_range(1) == 1);
      end
      reqIN = '0;
      busACKI = 0;
      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
